// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage feeding the 32x32 register bank.
package wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer: strict-order synchronous FIFO of writeback entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  wb_entry_t        mem [DEPTH];
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-bank write port: ALU results win, buffered loads fill idle cycles,
// and a busy scoreboard tracks outstanding loads for decode hazard checks.
module writeback_arbiter #(
  parameter int unsigned DATA_W     = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W     = wb_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluAddr,
  input  logic [DATA_W-1:0] AluData,
  input  logic              LoadValid,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadReady,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [31:0]       Busy,
  output logic [CNT_W-1:0]  Count,
  output logic              WawErr
);

  import wb_pkg::*;

  wb_entry_t   push_entry;
  wb_entry_t   head;
  logic        alu_take;
  logic        fifo_pop;
  logic        load_push;
  logic [31:0] busy_next;

  // An ALU result aimed at r0 counts as no ALU result, letting the FIFO drain.
  assign alu_take   = AluValid && (AluAddr != REG_ZERO);
  assign fifo_pop   = !alu_take && (Count != '0);
  assign LoadReady  = (Count < CNT_W'(FIFO_DEPTH));
  assign load_push  = LoadValid && LoadReady;
  assign push_entry = '{addr: LoadAddr, data: LoadData};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (load_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .count      (Count)
  );

  // Scoreboard update: a same-cycle issue to the popped register keeps it busy.
  always_comb begin
    busy_next = Busy;
    if (fifo_pop) busy_next[head.addr] = 1'b0;
    if (IssueValid && (IssueAddr != REG_ZERO)) busy_next[IssueAddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      Busy      <= '0;
      WawErr    <= 1'b0;
    end else begin
      Busy <= busy_next;
      if (alu_take && Busy[AluAddr]) WawErr <= 1'b1;
      if (alu_take) begin
        RegWrite  <= 1'b1;
        WriteAddr <= AluAddr;
        WriteData <= AluData;
      end else if (fifo_pop) begin
        RegWrite  <= (head.addr != REG_ZERO);
        WriteAddr <= head.addr;
        WriteData <= head.data;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: vector table, directed corner sequences, and random
// traffic compared every cycle against a queue-based reference model.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AluValid, LoadValid, IssueValid;
  logic [4:0]  AluAddr, LoadAddr, IssueAddr;
  logic [31:0] AluData, LoadData;
  logic        LoadReady, RegWrite, WawErr;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [31:0] Busy;
  logic [2:0]  Count;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AluValid   (AluValid),
    .AluAddr    (AluAddr),
    .AluData    (AluData),
    .LoadValid  (LoadValid),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .LoadReady  (LoadReady),
    .IssueValid (IssueValid),
    .IssueAddr  (IssueAddr),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .Busy       (Busy),
    .Count      (Count),
    .WawErr     (WawErr)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of pending loads plus the visible output state.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_busy;
  logic        m_waw, m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = '0;
    m_waw  = 1'b0;
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
  endtask

  task automatic compare_all();
    chk("RegWrite", 64'(RegWrite), 64'(m_we));
    chk("WriteAddr", 64'(WriteAddr), 64'(m_wa));
    chk("WriteData", 64'(WriteData), 64'(m_wd));
    chk("Busy", 64'(Busy), 64'(m_busy));
    chk("Count", 64'(Count), 64'(mq.size()));
    chk("WawErr", 64'(WawErr), 64'(m_waw));
    chk("LoadReady_post", 64'(LoadReady), 64'(mq.size() < 4));
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ia);
    logic ready;
    ent_t e;
    AluValid = av; AluAddr = aa; AluData = ad;
    LoadValid = lv; LoadAddr = la; LoadData = ld;
    IssueValid = iv; IssueAddr = ia;
    #1;
    ready = (mq.size() < 4);
    chk("LoadReady", 64'(LoadReady), 64'(ready));
    if (av && aa != 5'd0) begin
      if (m_busy[aa]) m_waw = 1'b1;
      m_we = 1'b1; m_wa = aa; m_wd = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = (e.a != 5'd0); m_wa = e.a; m_wd = e.d;
      m_busy[e.a] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
    m_busy[0] = 1'b0;
    if (lv && ready) mq.push_back('{la, ld});
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    AluValid = 1'b0; AluAddr = '0; AluData = '0;
    LoadValid = 1'b0; LoadAddr = '0; LoadData = '0;
    IssueValid = 1'b0; IssueAddr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWrite", 64'(RegWrite), 64'(0));
    chk("rst_Busy", 64'(Busy), 64'(0));
    chk("rst_Count", 64'(Count), 64'(0));
    chk("rst_LoadReady", 64'(LoadReady), 64'(1));
    rst_n = 1'b1;

    // ALU-only vectors with an empty FIFO.
    vt[0] = '{1'b1, 5'd7,  32'h0000_1234, 1'b1, 5'd7,  32'h0000_1234};
    vt[1] = '{1'b1, 5'd0,  32'hdead_beef, 1'b0, 5'd7,  32'h0000_1234};
    vt[2] = '{1'b0, 5'd3,  32'h0000_0055, 1'b0, 5'd7,  32'h0000_1234};
    vt[3] = '{1'b1, 5'd31, 32'hffff_ffff, 1'b1, 5'd31, 32'hffff_ffff};
    vt[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};
    vt[5] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd1,  32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      step(vt[i].av, vt[i].aa, vt[i].ad, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      chk("tbl_RegWrite", 64'(RegWrite), 64'(vt[i].we));
      chk("tbl_WriteAddr", 64'(WriteAddr), 64'(vt[i].wa));
      chk("tbl_WriteData", 64'(WriteData), 64'(vt[i].wd));
    end

    // ALU priority; loads drain afterwards in arrival order.
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    chk("prio_cnt1", 64'(Count), 64'(1));
    chk("prio_wa10", 64'(WriteAddr), 64'(10));
    step(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    chk("prio_wa11", 64'(WriteAddr), 64'(11));
    step(1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("prio_cnt2", 64'(Count), 64'(2));
    chk("prio_wa12", 64'(WriteAddr), 64'(12));
    idle();
    chk("prio_wa3", 64'(WriteAddr), 64'(3));
    chk("prio_wd3", 64'(WriteData), 64'(32'h33));
    chk("prio_we3", 64'(RegWrite), 64'(1));
    idle();
    chk("prio_wa4", 64'(WriteAddr), 64'(4));
    chk("prio_wd4", 64'(WriteData), 64'(32'h44));
    chk("prio_cnt0", 64'(Count), 64'(0));
    idle();
    chk("prio_idle_we", 64'(RegWrite), 64'(0));
    chk("prio_idle_hold", 64'(WriteAddr), 64'(4));

    // Fill the FIFO behind continuous ALU traffic, then drain.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd20, 32'(i), 1'b1, 5'(21 + i), 32'(32'h100 + i), 1'b0, 5'd0);
    chk("full_cnt4", 64'(Count), 64'(4));
    chk("full_notready", 64'(LoadReady), 64'(0));
    step(1'b1, 5'd20, 32'h55, 1'b1, 5'd25, 32'h125, 1'b0, 5'd0);
    chk("full_reject", 64'(Count), 64'(4));
    idle();
    chk("drain_cnt3", 64'(Count), 64'(3));
    chk("drain_ready", 64'(LoadReady), 64'(1));
    chk("drain_wa21", 64'(WriteAddr), 64'(21));
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("drain_order", 64'(WriteAddr), 64'(22 + i));
    end
    idle();
    chk("drain_empty_we", 64'(RegWrite), 64'(0));
    chk("drain_empty_cnt", 64'(Count), 64'(0));

    // Scoreboard set, clear on pop, and set-wins on re-issue.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    chk("sb_set", 64'(Busy[5]), 64'(1));
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5555, 1'b0, 5'd0);
    chk("sb_pending", 64'(Busy[5]), 64'(1));
    idle();
    chk("sb_clear", 64'(Busy[5]), 64'(0));
    chk("sb_write", 64'(WriteAddr), 64'(5));
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5656, 1'b1, 5'd5);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    chk("sb_setwins", 64'(Busy[5]), 64'(1));
    chk("sb_setwins_wr", 64'(WriteData), 64'(32'h5656));

    // WAW: ALU write to a register with an outstanding load.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("waw_flag", 64'(WawErr), 64'(1));
    chk("waw_write", 64'(WriteAddr), 64'(9));
    chk("waw_we", 64'(RegWrite), 64'(1));
    chk("waw_busy", 64'(Busy[9]), 64'(1));
    idle();
    chk("waw_sticky", 64'(WawErr), 64'(1));

    // Asynchronous reset with three loads buffered.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd2, 32'(i), 1'b1, 5'(6 + i), 32'(i), 1'b0, 5'd0);
    chk("rstm_cnt3", 64'(Count), 64'(3));
    #2;
    rst_n = 1'b0;
    AluValid = 1'b0; LoadValid = 1'b0; IssueValid = 1'b0;
    #1;
    model_reset();
    chk("rstm_RegWrite", 64'(RegWrite), 64'(0));
    chk("rstm_WriteAddr", 64'(WriteAddr), 64'(0));
    chk("rstm_WriteData", 64'(WriteData), 64'(0));
    chk("rstm_Busy", 64'(Busy), 64'(0));
    chk("rstm_Count", 64'(Count), 64'(0));
    chk("rstm_WawErr", 64'(WawErr), 64'(0));
    chk("rstm_LoadReady", 64'(LoadReady), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    chk("rstm_hold_we", 64'(RegWrite), 64'(0));
    rst_n = 1'b1;
    idle();
    chk("rstm_rel_cnt", 64'(Count), 64'(0));
    chk("rstm_rel_ready", 64'(LoadReady), 64'(1));

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
